// File: rtl/ipg_tx_arbiter_if.sv
// Bundle of the requester handshakes, the TX slot strobe and the abort/status
// outputs of the IPG transmit arbiter.
interface ipg_tx_arbiter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              req_valid;
  logic [2*DATA_WIDTH-1:0] req_data;
  logic [1:0]              req_last;
  logic [1:0]              req_ready;
  logic                    slot_avail;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic                    out_src;
  logic                    abort;
  logic                    abort_src;
  logic [7:0]              abort_count;
  logic                    busy;

  modport master (
    output req_valid, req_data, req_last, slot_avail,
    input  req_ready, out_valid, out_data, out_last, out_src,
    input  abort, abort_src, abort_count, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, slot_avail,
    output req_ready, out_valid, out_data, out_last, out_src,
    output abort, abort_src, abort_count, busy
  );
endinterface

// File: rtl/ipg_tx_arbiter.sv
// Two-requester, message-locked round-robin arbiter feeding one registered
// IPG chunk stage toward TX, with a mid-message stall timeout and flush.
module ipg_tx_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  ipg_tx_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_e                state_q;
  logic                  owner_q;
  logic                  rr_ptr_q;
  logic [CNT_W-1:0]      stall_q;
  logic [CNT_W-1:0]      stall_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  out_src_q;
  logic                  abort_q;
  logic                  abort_src_q;
  logic [7:0]            abort_count_q;

  logic [1:0]            ready;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  beat;
  logic                  xfer;
  logic                  timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    own_valid = bus.req_valid[owner_q];
    own_last  = bus.req_last[owner_q];
    own_data  = owner_q ? bus.req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                        : bus.req_data[DATA_WIDTH-1:0];

    // Only the owner is ever offered ready; FLUSH swallows beats unconditionally.
    ready = 2'b00;
    case (state_q)
      BUSY:    ready[owner_q] = !out_valid_q || bus.slot_avail;
      FLUSH:   ready[owner_q] = 1'b1;
      default: ready = 2'b00;
    endcase

    beat = own_valid && ready[owner_q];
    xfer = beat && (state_q == BUSY);

    stall_d     = stall_q;
    timeout_hit = 1'b0;
    if (state_q == BUSY) begin
      if (xfer) begin
        stall_d = '0;
      end else if (!own_valid && (TIMEOUT_CYCLES > 0) && (stall_q != LIMIT)) begin
        stall_d = stall_q + 1'b1;
      end
      // A valid-but-blocked owner is never timed out, so a final beat wins a tie.
      timeout_hit = (TIMEOUT_CYCLES > 0) && !own_valid && (stall_d == LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      rr_ptr_q      <= 1'b0;
      stall_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_src_q     <= 1'b0;
      abort_q       <= 1'b0;
      abort_src_q   <= 1'b0;
      abort_count_q <= 8'd0;
    end else begin
      abort_q <= 1'b0;
      stall_q <= stall_d;

      case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            owner_q <= (&bus.req_valid) ? rr_ptr_q : bus.req_valid[1];
            stall_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && own_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= ~owner_q;
          end else if (timeout_hit) begin
            state_q       <= FLUSH;
            stall_q       <= '0;
            abort_q       <= 1'b1;
            abort_src_q   <= owner_q;
            abort_count_q <= sat_inc8(abort_count_q);
          end
        end
        FLUSH: begin
          if (beat && own_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= ~owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Output stage drains independently of the arbitration state.
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= own_data;
        out_last_q  <= own_last;
        out_src_q   <= owner_q;
      end else if (bus.slot_avail) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_src     = out_src_q;
  assign bus.abort       = abort_q;
  assign bus.abort_src   = abort_src_q;
  assign bus.abort_count = abort_count_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
